// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - CP0 register numbers, exception codes and handler entry PC
package cp0_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] CP0_HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt request
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2025_0007,
    parameter logic [31:0] HANDLER_PC = CP0_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC,
    output logic        Req
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // Request generation: no nesting while EXL is set; interrupts also gated by IE/IM
    always_comb begin
        int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
        exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
        Req     = int_req | exc_req;
    end

    // Next-state: Req beats eret, eret beats mtc0 (EXL bit only)
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = HWInt;
        if (Req) begin
            exl_d      = 1'b1;
            exc_code_d = int_req ? EXC_INT : ExcCodeIn;
            bd_d       = BDIn;
            epc_d      = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (WE && (A == CP0_SR)) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end
            if (WE && (A == CP0_EPC)) begin
                epc_d = DIn;
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // Register assembly and mfc0 read mux; reads reflect pre-edge state
    always_comb begin
        sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
        cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
        case (A)
            CP0_SR:    DOut = sr_val;
            CP0_CAUSE: DOut = cause_val;
            CP0_EPC:   DOut = epc_q;
            CP0_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

    // eret target forwards a same-cycle mtc0 EPC so back-to-back mtc0/eret resolves
    always_comb begin
        EPCOut    = (WE && (A == CP0_EPC)) ? DIn : epc_q;
        HandlerPC = HANDLER_PC;
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed self-checking bench for cp0_unit
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        Req;

    int checks = 0;
    int errors = 0;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .DIn       (DIn),
        .WE        (WE),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .DOut      (DOut),
        .EPCOut    (EPCOut),
        .HandlerPC (HandlerPC),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        A = addr;
        #1;
        check(tag, DOut, exp);
    endtask

    initial begin
        reset = 1'b1; A = 5'd0; DIn = 32'd0; WE = 1'b0; VPC = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        step();
        step();
        reset = 1'b0;

        rd(5'd12, "reset_sr", 32'h0);
        rd(5'd13, "reset_cause", 32'h0);
        rd(5'd14, "reset_epc", 32'h0);
        rd(5'd15, "prid", 32'h2025_0007);
        rd(5'd16, "unmapped_read", 32'h0);
        check("handler_pc", HandlerPC, 32'h0000_4180);
        HWInt = 6'h3F;
        #1;
        check("reset_req_masked", {31'd0, Req}, 32'd0);

        HWInt = 6'h00;
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401;
        step();
        WE = 1'b0;
        rd(5'd12, "mtc0_sr", 32'h0000_0401);

        HWInt = 6'h01; VPC = 32'h3010; BDIn = 1'b0;
        #1;
        check("int_req", {31'd0, Req}, 32'd1);
        step();
        HWInt = 6'h00;
        rd(5'd14, "int_epc", 32'h3010);
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr_exl", 32'h0000_0403);
        check("int_req_after", {31'd0, Req}, 32'd0);

        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        rd(5'd12, "eret_sr", 32'h0000_0401);
        ExcCodeIn = 5'd12; BDIn = 1'b1; VPC = 32'h3024;
        #1;
        check("ov_req", {31'd0, Req}, 32'd1);
        step();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        rd(5'd14, "ov_epc_bd", 32'h3020);
        rd(5'd13, "ov_cause", 32'h8000_0030);

        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        HWInt = 6'h01; ExcCodeIn = 5'd10; VPC = 32'h3040;
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_0000;
        #1;
        check("both_req", {31'd0, Req}, 32'd1);
        step();
        WE = 1'b0; ExcCodeIn = 5'd0;
        rd(5'd13, "both_cause_int", 32'h0000_0400);
        rd(5'd12, "suppressed_mtc0_sr", 32'h0000_0403);
        rd(5'd14, "both_epc", 32'h3040);

        check("exl_blocks_int", {31'd0, Req}, 32'd0);
        EXLClr = 1'b1;
        #1;
        check("exl_blocks_during_eret", {31'd0, Req}, 32'd0);
        step();
        EXLClr = 1'b0; VPC = 32'h3050;
        #1;
        check("pending_int_after_eret", {31'd0, Req}, 32'd1);
        step();
        HWInt = 6'h00;
        rd(5'd14, "pending_epc", 32'h3050);

        check("epcout_reg", EPCOut, 32'h3050);
        WE = 1'b1; A = 5'd14; DIn = 32'h3100; EXLClr = 1'b1;
        #1;
        check("epcout_fwd", EPCOut, 32'h3100);
        check("eret_no_req", {31'd0, Req}, 32'd0);
        step();
        WE = 1'b0; EXLClr = 1'b0;
        rd(5'd14, "mtc0_epc", 32'h3100);
        rd(5'd12, "eret_mtc0_sr", 32'h0000_0401);

        ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h0000_0002;
        #1;
        check("adel_req", {31'd0, Req}, 32'd1);
        step();
        BDIn = 1'b0;
        rd(5'd14, "epc_wrap", 32'hFFFF_FFFE);
        rd(5'd13, "adel_cause", 32'h8000_0010);
        ExcCodeIn = 5'd5;
        #1;
        check("exl_blocks_exc", {31'd0, Req}, 32'd0);

        ExcCodeIn = 5'd0;
        WE = 1'b1; A = 5'd13; DIn = 32'hFFFF_FFFF;
        step();
        WE = 1'b0;
        rd(5'd13, "cause_readonly", 32'h8000_0010);

        HWInt = 6'h01; reset = 1'b1;
        step();
        reset = 1'b0; HWInt = 6'h00;
        rd(5'd12, "midreset_sr", 32'h0);
        rd(5'd13, "midreset_cause", 32'h0);
        rd(5'd14, "midreset_epc", 32'h0);
        check("midreset_req", {31'd0, Req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor 0 for the P7 exception-capable pipelined MIPS core; sits beside the M stage.
- Consumes the per-instruction exception code, branch-delay flag and PC carried down the F/D, D/E and E/M pipeline registers, plus external hardware interrupt lines.
- Produces Req, the exception/interrupt request that flushes every pipeline register and redirects fetch to the handler at 0x00004180.
- Holds SR, Cause, EPC and PRId; serves mfc0 reads and mtc0 writes; clears EXL on eret.

Parameters:
- PRID_VALUE, 32'h2025_0007, read-only value returned for register 15.
- HANDLER_PC, 32'h0000_4180, exception entry PC driven on HandlerPC.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- A  input  5  CP0 register number for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC, 15 PRId)
- DIn  input  32  mtc0 write data (M-stage forwarded rt)
- WE  input  1  mtc0 write enable (M stage)
- VPC  input  32  PC of the M-stage (victim) instruction
- BDIn  input  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  input  5  M-stage exception code, 0 = none
- HWInt  input  6  hardware interrupt lines, level-sensitive
- EXLClr  input  1  eret in M stage
- DOut  output  32  mfc0 read data, combinational on A
- EPCOut  output  32  current EPC, used as the eret target
- HandlerPC  output  32  constant HANDLER_PC
- Req  output  1  take exception/interrupt this cycle, combinational

Behaviour:
- SR fields: IM = bits [15:10], EXL = bit 1, IE = bit 0. All other SR bits read as 0.
- Cause fields: BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]. All other Cause bits read as 0.
- Reset: IM = 0, EXL = 0, IE = 0, BD = 0, IP = 0, ExcCode = 0, EPC = 0. Req is therefore 0 out of reset.
- IntReq = (|(HWInt & IM)) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq, combinational in the same cycle (zero latency).
- On a clock edge with Req = 1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn. An interrupt has priority over a synchronous exception in the same cycle.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC - 32'd4 : VPC, full 32-bit subtraction with wrap-around. Bits [1:0] are kept as given (AdEL/AdEs handlers read them).
- IP <= HWInt on every non-reset edge, regardless of Req or EXL.
- mtc0 (WE = 1, Req = 0):
  - A = 12 writes IM, EXL and IE from the matching DIn bits.
  - A = 14 writes EPC = DIn.
  - A = 13 and A = 15 are read-only for software; writes are ignored.
  - Any other A is ignored.
- Writes suppressed: WE is ignored whenever Req = 1 in that cycle, because the victim instruction must not commit.
- EXLClr = 1 with Req = 0: EXL <= 0 at the edge.
- Precedence within one edge: reset > Req > EXLClr > WE.
  - If EXLClr and WE target SR in the same cycle, EXLClr wins on the EXL bit only; IM and IE still take DIn.
- DOut:
  - 12 returns the assembled SR.
  - 13 returns the assembled Cause.
  - 14 returns EPC.
  - 15 returns PRID_VALUE.
  - Any other A returns 0.
  - No write-to-read bypass; reads show register state before the edge.
- EPCOut = EPC register, with one exception: it equals DIn when WE = 1 and A = 14 in the same cycle, so that an mtc0 EPC immediately followed by eret resolves correctly.
- While EXL = 1, Req stays 0 for both interrupts and exceptions (no nesting). Pending HWInt is taken on the first cycle after EXL clears, provided IE and IM allow it.
- Reset mid-handler: all state returns to the reset values above and Req drops in the same cycle.
- A Req that coincides with a bubble (VPC carries the flush PC from the pipeline registers) is legal; EPC records that PC.

Decomposition:
- Shared package/header holds:
  - CP0 register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - ExcCode constants: Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12.
  - HANDLER_PC.
- Single module; no sub-module is warranted.

Test Plan:
- Reset, then read A = 12, 13 and 14 -> DOut = 0 for each; Req = 0 with HWInt = 6'h3F.
- mtc0 SR = 32'h0000_0401 (IM[0], IE), then HWInt = 6'h01, VPC = 32'h3010, BDIn = 0:
  - Req = 1 in the same cycle.
  - Next cycle EPC = 32'h3010, ExcCode = 0, EXL = 1, Req = 0.
- EXL = 0, ExcCodeIn = 12, BDIn = 1, VPC = 32'h3024:
  - Req = 1.
  - EPC = 32'h3020, Cause = 32'h8000_0030.
- Interrupt and exception together (SR = 32'h0000_0401, HWInt = 6'h01, ExcCodeIn = 10) -> ExcCode = 0, Req = 1.
- mtc0 to A = 12 with DIn = 32'h0000_0401 while Req = 1 -> SR keeps its old IM/IE, EXL = 1.
- EXL = 1 with HWInt pending:
  - Req = 0.
  - EXLClr pulse -> Req = 1 on the following cycle.
- mtc0 A = 14, DIn = 32'h3100 in the same cycle as an eret read -> EPCOut = 32'h3100.
